smultadd_arbiter: RTL

Round-robin scheduler that shares one external signed multiply-add pipeline among NREQ requesters. The pipeline computes out = a*b + c*d. It has an enable-gated input stage and a fixed LAT-cycle latency.
The block arbitrates valid/ready requests and supports locked bursts for dot-product style streams. It drives the pipeline operands and enable, and tags each result with the issuing requester's ID through a latency-matched shift register.
It sits between the DSP stream clients and a single shared multiply-add instance. Both the block and the instance run on the same clk and aclr.

---
 rtl/smultadd_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/smultadd_arbiter.sv
// Purpose: round-robin share of one external signed multiply-add (a*b + c*d) among NREQ requesters, with locked bursts.
// Latency: operands reach the multiply-add in the grant cycle; the result and its {id, last} tag appear LAT cycles later.
// Backpressure: requesters are held off by req_ready; results carry no backpressure and must be taken on every res_valid.
module smultadd_arbiter #(
    parameter int  DWIDTH = 16,
    parameter int  NREQ   = 4,
    parameter int  LAT    = 3,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*DWIDTH-1:0] req_a,
    input  logic [NREQ*DWIDTH-1:0] req_b,
    input  logic [NREQ*DWIDTH-1:0] req_c,
    input  logic [NREQ*DWIDTH-1:0] req_d,
    output logic [DWIDTH-1:0]      ma_da,
    output logic [DWIDTH-1:0]      ma_db,
    output logic [DWIDTH-1:0]      ma_dc,
    output logic [DWIDTH-1:0]      ma_dd,
    output logic                   ma_ena,
    input  logic [2*DWIDTH:0]      ma_out,
    output logic                   res_valid,
    output logic [IDW-1:0]         res_id,
    output logic                   res_last,
    output logic [2*DWIDTH:0]      res_data,
    output logic                   busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] owner, owner_nxt;
    logic [IDW-1:0] gidx, gidx_inc;
    logic           sel;
    logic           xfer;
    logic           xlast;
    int             j;

    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_last;
    logic [IDW-1:0] tag_id [LAT];

    // Pick the candidate requester: the lock owner, or the first valid one at/after ptr.
    always_comb begin
        sel  = 1'b0;
        gidx = '0;
        j    = 0;
        if (state == LOCKED) begin
            sel  = 1'b1;
            gidx = owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                j = (int'(ptr) + k) % NREQ;
                if (!sel && req_valid[j]) begin
                    sel  = 1'b1;
                    gidx = IDW'(j);
                end
            end
        end
    end

    // Handshake: ready is one-hot on the candidate; everything is suppressed while in reset.
    always_comb begin
        req_ready = '0;
        if (!aclr && sel) begin
            req_ready[gidx] = 1'b1;
        end
        xfer     = !aclr && sel && req_valid[gidx];
        xlast    = req_last[gidx];
        gidx_inc = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    end

    // Next-state: a last beat releases the lock and moves ptr past the granted requester.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        if (xfer) begin
            if (xlast) begin
                state_nxt = IDLE;
                ptr_nxt   = gidx_inc;
            end else begin
                state_nxt = LOCKED;
                owner_nxt = gidx;
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (aclr) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    // Operand mux to the shared multiply-add; zero when nothing is issued.
    always_comb begin
        ma_ena = xfer;
        ma_da  = '0;
        ma_db  = '0;
        ma_dc  = '0;
        ma_dd  = '0;
        if (xfer) begin
            ma_da = req_a[int'(gidx)*DWIDTH +: DWIDTH];
            ma_db = req_b[int'(gidx)*DWIDTH +: DWIDTH];
            ma_dc = req_c[int'(gidx)*DWIDTH +: DWIDTH];
            ma_dd = req_d[int'(gidx)*DWIDTH +: DWIDTH];
        end
    end

    // Tag shift register matched to the multiply-add latency; id/last are zeroed on idle cycles.
    always_ff @(posedge clk) begin
        if (aclr) begin
            tag_v    <= '0;
            tag_last <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]    <= xfer;
            tag_id[0]   <= xfer ? gidx : '0;
            tag_last[0] <= xfer & xlast;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k]    <= tag_v[k-1];
                tag_id[k]   <= tag_id[k-1];
                tag_last[k] <= tag_last[k-1];
            end
        end
    end

    // Result presentation and activity flag.
    always_comb begin
        res_valid = tag_v[LAT-1];
        res_id    = tag_id[LAT-1];
        res_last  = tag_last[LAT-1];
        res_data  = tag_v[LAT-1] ? ma_out : '0;
        busy      = (state == LOCKED) || (|tag_v);
    end

endmodule
